// File: rtl/vrp_ingress_buf_pkg.sv
// Shared helpers for the ingress buffer bank: the occupancy counter width
// and an elaboration-time parameter legality check.
package vrp_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int depth, input int afull_th);
    return is_pow2(depth) && (depth >= 2) && (afull_th >= 1) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/vrp_ingress_buf_if.sv
// Requester-side push and arbiter-side pop bundle for the ingress buffer bank.
interface vrp_ingress_buf_if
  import vrp_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0]     v_vld_in;
  logic [WIDTH-1:0]     v_rdy_in;
  logic [PLD_WIDTH-1:0] v_pld_in  [WIDTH];
  logic [WIDTH-1:0]     v_vld_out;
  logic [WIDTH-1:0]     v_rdy_out;
  logic [PLD_WIDTH-1:0] v_pld_out [WIDTH];
  logic [WIDTH-1:0]     v_afull;
  logic [CNT_W-1:0]     v_cnt     [WIDTH];

  modport master (
    output v_vld_in, v_pld_in, v_rdy_out,
    input  v_rdy_in, v_vld_out, v_pld_out, v_afull, v_cnt
  );

  modport slave (
    input  v_vld_in, v_pld_in, v_rdy_out,
    output v_rdy_in, v_vld_out, v_pld_out, v_afull, v_cnt
  );
endinterface

// File: rtl/vrp_ingress_buf_fifo.sv
// Single-channel synchronous FIFO with flush, occupancy count and almost-full.
// The count register alone decides full/empty; the head is read from storage only.
module vrp_sync_fifo
  import vrp_pkg::*;
#(
  parameter int PLD_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = 3,
  localparam int CNT_W    = cnt_w(DEPTH),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 push_vld_i,
  output logic                 push_rdy_o,
  input  logic [PLD_WIDTH-1:0] push_pld_i,
  output logic                 pop_vld_o,
  input  logic                 pop_rdy_i,
  output logic [PLD_WIDTH-1:0] pop_pld_o,
  output logic                 afull_o,
  output logic [CNT_W-1:0]     cnt_o
);

  if (!params_legal(DEPTH, AFULL_TH)) begin : g_param_err
    $error("vrp_sync_fifo: DEPTH must be a power of two >= 2 and 1 <= AFULL_TH <= DEPTH");
  end

  logic [PLD_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 full, empty, push, pop;

  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign push_rdy_o = ~full & ~flush_i;
  assign pop_vld_o  = ~empty;
  assign push       = push_vld_i & push_rdy_o;
  assign pop        = pop_vld_o & pop_rdy_i;
  assign pop_pld_o  = mem_q[rd_ptr_q];
  assign afull_o    = (cnt_q >= CNT_W'(AFULL_TH));
  assign cnt_o      = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      // pops in a flush cycle are dropped together with the contents
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= push_pld_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (cnt_q == '0)));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/vrp_ingress_buf.sv
// Per-requester ingress buffer bank feeding the valid/ready arbiter.
// One independent FIFO per channel; this level only fans the arrays out and back.
module vrp_ingress_buf
  import vrp_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  vrp_ingress_buf_if.slave  bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    vrp_sync_fifo #(
      .PLD_WIDTH (PLD_WIDTH),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .push_vld_i (bus.v_vld_in[i]),
      .push_rdy_o (bus.v_rdy_in[i]),
      .push_pld_i (bus.v_pld_in[i]),
      .pop_vld_o  (bus.v_vld_out[i]),
      .pop_rdy_i  (bus.v_rdy_out[i]),
      .pop_pld_o  (bus.v_pld_out[i]),
      .afull_o    (bus.v_afull[i]),
      .cnt_o      (bus.v_cnt[i])
    );
  end

endmodule

// File: tb/tb_vrp_ingress_buf.sv
// Scenario tests plus randomized traffic for vrp_ingress_buf, checked against
// per-channel payload queues.
module tb_vrp_ingress_buf;
  localparam int W  = 4;
  localparam int P  = 32;
  localparam int D  = 4;
  localparam int TH = 3;

  logic clk, rst_n, flush;
  int   errors = 0;
  int   checks = 0;

  logic [P-1:0] mq [W][$];

  vrp_ingress_buf_if #(.WIDTH(W), .PLD_WIDTH(P), .DEPTH(D)) bus ();

  vrp_ingress_buf #(.WIDTH(W), .PLD_WIDTH(P), .DEPTH(D), .AFULL_TH(TH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    flush = 1'b0;
    bus.v_vld_in  = '0;
    bus.v_rdy_out = '0;
    for (int c = 0; c < W; c++) bus.v_pld_in[c] = '0;
  endtask

  // Model advance: decide transfers from the inputs present before the edge.
  task automatic tick();
    bit           p [W];
    bit           o [W];
    logic [P-1:0] d [W];
    bit           f;
    f = flush;
    for (int c = 0; c < W; c++) begin
      p[c] = bus.v_vld_in[c] && (mq[c].size() < D) && !f;
      o[c] = bus.v_rdy_out[c] && (mq[c].size() > 0);
      d[c] = bus.v_pld_in[c];
    end
    @(posedge clk);
    for (int c = 0; c < W; c++) begin
      if (f) mq[c].delete();
      else begin
        if (o[c]) void'(mq[c].pop_front());
        if (p[c]) mq[c].push_back(d[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.v_rdy_in !== 4'b1111) begin errors++; $display("FAIL reset_rdy_in got=%b exp=1111", bus.v_rdy_in); end
    checks++; if (bus.v_vld_out !== 4'b0000) begin errors++; $display("FAIL reset_vld_out got=%b exp=0000", bus.v_vld_out); end
    checks++; if (bus.v_afull !== 4'b0000) begin errors++; $display("FAIL reset_afull got=%b exp=0000", bus.v_afull); end
    for (int c = 0; c < W; c++) begin
      checks++; if (bus.v_cnt[c] !== 3'd0) begin errors++; $display("FAIL reset_cnt ch%0d got=%0d exp=0", c, bus.v_cnt[c]); end
      checks++; if (bus.v_pld_out[c] !== 32'h0) begin errors++; $display("FAIL reset_pld ch%0d got=%h exp=0", c, bus.v_pld_out[c]); end
    end
  endtask

  task automatic test_fill_drain();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      bus.v_vld_in[0] = 1'b1;
      bus.v_pld_in[0] = 32'(32'hA1 + k);
      #1;
      checks++; if (bus.v_rdy_in[0] !== 1'b1) begin errors++; $display("FAIL fill_rdy k=%0d got=%b exp=1", k, bus.v_rdy_in[0]); end
      checks++; if (bus.v_cnt[0] !== 3'(k)) begin errors++; $display("FAIL fill_cnt k=%0d got=%0d exp=%0d", k, bus.v_cnt[0], k); end
      checks++; if (bus.v_afull[0] !== (k >= TH)) begin errors++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, bus.v_afull[0], k >= TH); end
      tick();
    end
    bus.v_vld_in[0] = 1'b0;
    #1;
    checks++; if (bus.v_cnt[0] !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", bus.v_cnt[0]); end
    checks++; if (bus.v_rdy_in[0] !== 1'b0) begin errors++; $display("FAIL full_rdy got=%b exp=0", bus.v_rdy_in[0]); end
    checks++; if (bus.v_afull[0] !== 1'b1) begin errors++; $display("FAIL full_afull got=%b exp=1", bus.v_afull[0]); end
    bus.v_rdy_out[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.v_vld_out[0] !== 1'b1) begin errors++; $display("FAIL drain_vld k=%0d got=%b exp=1", k, bus.v_vld_out[0]); end
      checks++; if (bus.v_pld_out[0] !== 32'(32'hA1 + k)) begin errors++; $display("FAIL drain_pld k=%0d got=%h exp=%h", k, bus.v_pld_out[0], 32'hA1 + k); end
      tick();
    end
    #1;
    checks++; if (bus.v_vld_out[0] !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.v_vld_out[0]); end
    idle_inputs();
  endtask

  task automatic test_latency();
    idle_inputs();
    bus.v_vld_in[2] = 1'b1;
    bus.v_pld_in[2] = 32'h55;
    #1;
    checks++; if (bus.v_vld_out[2] !== 1'b0) begin errors++; $display("FAIL lat_same_cycle got=%b exp=0", bus.v_vld_out[2]); end
    tick();
    bus.v_vld_in[2] = 1'b0;
    #1;
    checks++; if (bus.v_vld_out[2] !== 1'b1) begin errors++; $display("FAIL lat_next_vld got=%b exp=1", bus.v_vld_out[2]); end
    checks++; if (bus.v_pld_out[2] !== 32'h55) begin errors++; $display("FAIL lat_next_pld got=%h exp=55", bus.v_pld_out[2]); end
    bus.v_rdy_out[2] = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [P-1:0] exp_head;
    idle_inputs();
    bus.v_vld_in[1] = 1'b1;
    bus.v_pld_in[1] = 32'h10;
    tick();
    exp_head = 32'h10;
    bus.v_rdy_out[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.v_pld_in[1] = 32'(32'h20 + i);
      #1;
      checks++; if (bus.v_cnt[1] !== 3'd1) begin errors++; $display("FAIL stream_cnt i=%0d got=%0d exp=1", i, bus.v_cnt[1]); end
      checks++; if (bus.v_pld_out[1] !== exp_head) begin errors++; $display("FAIL stream_head i=%0d got=%h exp=%h", i, bus.v_pld_out[1], exp_head); end
      exp_head = 32'(32'h20 + i);
      tick();
    end
    bus.v_vld_in[1] = 1'b0;
    #1;
    checks++; if (bus.v_pld_out[1] !== exp_head) begin errors++; $display("FAIL stream_last got=%h exp=%h", bus.v_pld_out[1], exp_head); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full_push();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      bus.v_vld_in[3] = 1'b1;
      bus.v_pld_in[3] = 32'(32'h30 + k);
      tick();
    end
    bus.v_pld_in[3]  = 32'h99;
    bus.v_rdy_out[3] = 1'b1;
    #1;
    checks++; if (bus.v_rdy_in[3] !== 1'b0) begin errors++; $display("FAIL fullpush_rdy got=%b exp=0", bus.v_rdy_in[3]); end
    tick();
    bus.v_rdy_out[3] = 1'b0;
    #1;
    checks++; if (bus.v_cnt[3] !== 3'd3) begin errors++; $display("FAIL fullpush_cnt3 got=%0d exp=3", bus.v_cnt[3]); end
    checks++; if (bus.v_rdy_in[3] !== 1'b1) begin errors++; $display("FAIL fullpush_rdy_next got=%b exp=1", bus.v_rdy_in[3]); end
    tick();
    bus.v_vld_in[3] = 1'b0;
    #1;
    checks++; if (bus.v_cnt[3] !== 3'd4) begin errors++; $display("FAIL fullpush_cnt4 got=%0d exp=4", bus.v_cnt[3]); end
    bus.v_rdy_out[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [P-1:0] e;
      e = (k < 3) ? 32'(32'h31 + k) : 32'h99;
      #1;
      checks++; if (bus.v_pld_out[3] !== e) begin errors++; $display("FAIL fullpush_order k=%0d got=%h exp=%h", k, bus.v_pld_out[3], e); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int n = 0; n < 2; n++) begin
      bus.v_vld_in = '1;
      for (int c = 0; c < W; c++) bus.v_pld_in[c] = 32'(c * 16 + n);
      tick();
    end
    flush = 1'b1;
    bus.v_rdy_out = 4'b0101;
    #1;
    checks++; if (bus.v_rdy_in !== 4'b0000) begin errors++; $display("FAIL flush_rdy got=%b exp=0000", bus.v_rdy_in); end
    checks++; if (bus.v_vld_out !== 4'b1111) begin errors++; $display("FAIL flush_vld_pre got=%b exp=1111", bus.v_vld_out); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.v_vld_out !== 4'b0000) begin errors++; $display("FAIL flush_vld_post got=%b exp=0000", bus.v_vld_out); end
    for (int c = 0; c < W; c++) begin
      checks++; if (bus.v_cnt[c] !== 3'd0) begin errors++; $display("FAIL flush_cnt ch%0d got=%0d exp=0", c, bus.v_cnt[c]); end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int n = 0; n < 3; n++) begin
      bus.v_vld_in = '1;
      for (int c = 0; c < W; c++) bus.v_pld_in[c] = $urandom;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.v_vld_out !== 4'b0000) begin errors++; $display("FAIL rstmid_vld got=%b exp=0000", bus.v_vld_out); end
    checks++; if (bus.v_rdy_in !== 4'b1111) begin errors++; $display("FAIL rstmid_rdy got=%b exp=1111", bus.v_rdy_in); end
    for (int c = 0; c < W; c++) begin
      checks++; if (bus.v_cnt[c] !== 3'd0) begin errors++; $display("FAIL rstmid_cnt ch%0d got=%0d exp=0", c, bus.v_cnt[c]); end
      checks++; if (bus.v_pld_out[c] !== 32'h0) begin errors++; $display("FAIL rstmid_pld ch%0d got=%h exp=0", c, bus.v_pld_out[c]); end
      mq[c].delete();
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [W-1:0] e_vld, e_rdy, e_af;
      flush = ($urandom_range(0, 24) == 0);
      for (int c = 0; c < W; c++) begin
        bus.v_vld_in[c]  = ($urandom_range(0, 3) != 0);
        bus.v_rdy_out[c] = ($urandom_range(0, 2) != 0);
        bus.v_pld_in[c]  = $urandom;
      end
      #1;
      for (int c = 0; c < W; c++) begin
        e_vld[c] = (mq[c].size() > 0);
        e_rdy[c] = (mq[c].size() < D) && !flush;
        e_af[c]  = (mq[c].size() >= TH);
      end
      checks++; if (bus.v_vld_out !== e_vld) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, bus.v_vld_out, e_vld); end
      checks++; if (bus.v_rdy_in !== e_rdy) begin errors++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, bus.v_rdy_in, e_rdy); end
      checks++; if (bus.v_afull !== e_af) begin errors++; $display("FAIL rnd_afull cyc=%0d got=%b exp=%b", cyc, bus.v_afull, e_af); end
      for (int c = 0; c < W; c++) begin
        checks++; if (bus.v_cnt[c] !== 3'(mq[c].size())) begin errors++; $display("FAIL rnd_cnt cyc=%0d ch%0d got=%0d exp=%0d", cyc, c, bus.v_cnt[c], mq[c].size()); end
        if (mq[c].size() > 0) begin
          checks++; if (bus.v_pld_out[c] !== mq[c][0]) begin errors++; $display("FAIL rnd_pld cyc=%0d ch%0d got=%h exp=%h", cyc, c, bus.v_pld_out[c], mq[c][0]); end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_latency();
    test_stream();
    test_full_push();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vrp_ingress_buf.md
Name: vrp_ingress_buf

Overview:
Per-requester ingress buffering bank placed directly upstream of the valid/ready arbiter.
- Each of WIDTH requester channels has its own small synchronous FIFO.
- The FIFO heads drive the arbiter's v_vld_s/v_pld_s inputs; the arbiter's v_rdy_s grants pop them.
- Decouples requester timing from arbitration and exposes per-channel occupancy and almost-full for upstream flow control.

Parameters:
WIDTH, 4, number of requester channels (>=1)
PLD_WIDTH, 32, payload bits per entry
DEPTH, 4, entries per channel FIFO; power of two, >=2
AFULL_TH, 3, occupancy at or above which v_afull[i] asserts (1..DEPTH)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all channels
v_vld_in  input  WIDTH  per-channel push valid
v_rdy_in  output  WIDTH  per-channel push ready
v_pld_in  input  PLD_WIDTH x WIDTH (unpacked array)  per-channel push payload
v_vld_out  output  WIDTH  per-channel head valid (to arbiter v_vld_s)
v_rdy_out  input  WIDTH  per-channel pop ready (from arbiter v_rdy_s)
v_pld_out  output  PLD_WIDTH x WIDTH (unpacked array)  per-channel head payload (to arbiter v_pld_s)
v_afull  output  WIDTH  per-channel almost-full
v_cnt  output  CNT_W x WIDTH (unpacked array)  per-channel occupancy, CNT_W = $clog2(DEPTH+1)

Behaviour:
- Reset (async, rst_n=0): all rd/wr pointers=0, counts=0, storage=0. Hence v_vld_out=0, v_rdy_in=all 1s, v_pld_out=0, v_afull=0, v_cnt=0. Reset mid-traffic discards all contents immediately.
- Channels are fully independent; no cross-channel interaction.
- push[i] = v_vld_in[i] & v_rdy_in[i]. pop[i] = v_vld_out[i] & v_rdy_out[i].
- v_rdy_in[i] = ~full[i] & ~flush. Depends only on state and flush, never on v_rdy_out, so there is no combinational in->out path.
- v_vld_out[i] = ~empty[i]. v_pld_out[i] = mem[i][rd_ptr[i]], driven from registered storage with no write-through bypass.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- Pointers: $clog2(DEPTH) bits, natural wrap at DEPTH. The count register is authoritative for full (cnt==DEPTH) and empty (cnt==0).
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Full channel: v_rdy_in=0. A pop in that cycle frees space only from the next cycle; no same-cycle push-on-full.
- Empty channel: v_vld_out=0; v_rdy_out is ignored.
- Simultaneous push and pop with cnt==1: head advances to the new entry, cnt stays 1, and the new entry is at the head next cycle.
- v_afull[i] = (cnt[i] >= AFULL_TH), combinational from the count register.
- Flush:
  - flush=1 for one cycle clears all pointers and counts at the next edge.
  - Pushes are blocked that cycle (v_rdy_in=0).
  - Pops that cycle are discarded along with everything else; v_vld_out still reflects pre-flush state that cycle.
  - Storage contents are not cleared; v_pld_out is don't-care while empty.
- Payload ordering within a channel is strictly FIFO. No entry is lost or duplicated outside flush and reset.
- Assertions (sim only): push never when cnt==DEPTH; pop never when cnt==0; cnt <= DEPTH.

Decomposition:
- Shared package vrp_pkg: function for CNT_W, plus parameter-legality checks (DEPTH power of two, 1<=AFULL_TH<=DEPTH).
- One sub-module, vrp_sync_fifo: single-channel FIFO with flush, cnt and afull, instantiated WIDTH times in a generate loop.
- The top level only fans arrays in and out.

Test Plan:
- Reset then idle, WIDTH=4, DEPTH=4 -> v_rdy_in=4'b1111, v_vld_out=0, v_cnt all 0, v_afull=0.
- Push 0xA1,0xA2,0xA3,0xA4 on ch0 with v_rdy_out=0 -> v_cnt[0]=4, v_rdy_in[0]=0, v_afull[0]=1 from cnt=3. Then pop 4 -> heads 0xA1..0xA4 in order, v_vld_out[0]=0 after.
- Single push 0x55 on ch2 in cycle N -> v_vld_out[2]=1 with v_pld_out[2]=0x55 in cycle N+1, not N.
- ch1 holds 1 entry 0x10; push 0x20 and pop in the same cycle -> v_cnt[1] stays 1, head=0x20. Repeat 100 cycles streaming -> cnt stays 1, order preserved.
- Full ch3 with v_rdy_out[3]=1 and v_vld_in[3]=1 -> no push that cycle; cnt goes 4->3; next cycle the push is accepted and cnt returns to 4.
- All channels at cnt=2, assert flush one cycle with v_vld_in all 1 -> v_rdy_in=0 that cycle, all cnt=0 next cycle. Also assert rst_n low mid-stream -> outputs return to reset values immediately.
